// File: rtl/note_player_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : note_player_pkg                                           |
// | Desc     : Shared FSM encoding, note-word fields and pitch table.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package note_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_FETCH = 2'd2,
    ST_PLAY  = 2'd3
  } state_t;

  localparam int c_pitch_msb = 7;
  localparam int c_pitch_lsb = 4;
  localparam int c_beats_msb = 3;
  localparam int c_beats_lsb = 0;

  localparam logic [3:0] c_rest_code = 4'd0;
  localparam int unsigned c_lowest_hz = 262;

  function automatic int unsigned pitch_hz(input logic [3:0] code);
    int unsigned f;
    f = 0;
    case (code)
      4'd1:  f = 262;
      4'd2:  f = 294;
      4'd3:  f = 330;
      4'd4:  f = 349;
      4'd5:  f = 392;
      4'd6:  f = 440;
      4'd7:  f = 494;
      4'd8:  f = 523;
      4'd9:  f = 587;
      4'd10: f = 659;
      4'd11: f = 698;
      4'd12: f = 784;
      4'd13: f = 880;
      4'd14: f = 988;
      4'd15: f = 1047;
      default: f = 0;
    endcase
    return f;
  endfunction

  // Rest code maps to a zero half-period, which the tone divider treats as silence.
  function automatic int unsigned half_period(input int unsigned clk_hz, input logic [3:0] code);
    int unsigned f;
    f = pitch_hz(code);
    if (code == c_rest_code || f == 0) return 0;
    return clk_hz / (2 * f);
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_player_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : note_player_if                                            |
// | Desc     : Song-ROM side inputs and buzzer/status outputs.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface note_player_if;
  logic       play;
  logic       loop;
  logic [7:0] rom_data;
  logic       last_in;
  logic       note_step;
  logic       buzz;
  logic       busy;
  logic       song_done;
  logic [3:0] cur_pitch;

  modport master (
    output play, loop, rom_data, last_in,
    input  note_step, buzz, busy, song_done, cur_pitch
  );

  modport slave (
    input  play, loop, rom_data, last_in,
    output note_step, buzz, busy, song_done, cur_pitch
  );
endinterface
`default_nettype wire

// File: rtl/note_player_tone_div.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tone_div                                                  |
// | Desc     : Square-wave divider; toggles every loaded half-period.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tone_div #(
  parameter int HP_W = 17
) (
  input  wire logic            clk,
  input  wire logic            rstn,
  input  wire logic            load,
  input  wire logic            en,
  input  wire logic [HP_W-1:0] hp,
  output logic                 tone
);

  logic [HP_W-1:0] r_hp;
  logic [HP_W-1:0] r_cnt;
  logic            r_tone;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hp   <= '0;
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (load) begin
      r_hp   <= hp;
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (!en || r_hp == '0) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (r_cnt == r_hp - HP_W'(1)) begin
      r_cnt  <= '0;
      r_tone <= ~r_tone;
    end else begin
      r_cnt  <= r_cnt + HP_W'(1);
    end
  end

  assign tone = r_tone;

endmodule
`default_nettype wire

// File: rtl/note_player.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : note_player                                               |
// | Desc     : Plays song-ROM note words on the buzzer, steps the        |
// |            address counter. Option macro: NOTE_GAP_EN (silences the |
// |            last quarter of each note's final beat).                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module note_player
  import note_player_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BEAT_HZ = 8,
  parameter int ROM_LAT = 1
) (
  input  wire logic   clk,
  input  wire logic   rstn,
  note_player_if.slave bus
);

  localparam int c_beat_div = CLK_HZ / BEAT_HZ;
  localparam int c_pre_w    = $clog2(c_beat_div);
  localparam int c_fc_w     = $clog2(ROM_LAT + 2);
  localparam int c_hp_w     = $clog2(CLK_HZ / (2 * c_lowest_hz) + 1);

  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(c_beat_div - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [c_fc_w-1:0]   r_fetch_cnt;
  logic [c_pre_w-1:0]  r_pre;
  logic [4:0]          r_beat;
  logic [4:0]          r_beats_total;
  logic [3:0]          r_pitch;
  logic                r_last;
  logic                r_song_done;
  logic                r_hold;

  logic                w_latch;
  logic                w_note_end;
  logic                w_final_beat;
  logic                w_song_end;
  logic                w_gap;
  logic                w_tone;
  logic [3:0]          w_rom_pitch;
  logic [3:0]          w_rom_beats;
  logic [c_hp_w-1:0]   w_hp_tab [16];

  assign w_rom_pitch = bus.rom_data[c_pitch_msb:c_pitch_lsb];
  assign w_rom_beats = bus.rom_data[c_beats_msb:c_beats_lsb];

  for (genvar g = 0; g < 16; g++) begin : g_hp_tab
    assign w_hp_tab[g] = c_hp_w'(half_period(CLK_HZ, 4'(g)));
  end

  assign w_final_beat = (r_beat == r_beats_total - 5'd1);
  assign w_note_end   = w_final_beat && (r_pre == c_pre_max);

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_song_end   = 1'b0;
    if (!bus.play) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // After a finished song stay parked until play is released.
          if (!r_hold) w_next_state = ST_STEP;
        end
        ST_STEP: begin
          w_next_state = ST_FETCH;
        end
        ST_FETCH: begin
          if (r_fetch_cnt == c_fc_w'(ROM_LAT)) begin
            w_latch      = 1'b1;
            w_next_state = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (w_note_end) begin
            if (r_last && !bus.loop) begin
              w_song_end   = 1'b1;
              w_next_state = ST_IDLE;
            end else begin
              w_next_state = ST_STEP;
            end
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Note latch, beat timing and status
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_cnt   <= '0;
      r_pre         <= '0;
      r_beat        <= '0;
      r_beats_total <= 5'd16;
      r_pitch       <= '0;
      r_last        <= 1'b0;
      r_song_done   <= 1'b0;
      r_hold        <= 1'b0;
    end else begin
      r_song_done <= w_song_end;

      if (!bus.play)      r_hold <= 1'b0;
      else if (w_song_end) r_hold <= 1'b1;

      if (r_state == ST_FETCH) r_fetch_cnt <= r_fetch_cnt + c_fc_w'(1);
      else                     r_fetch_cnt <= '0;

      if (w_latch) begin
        r_pitch       <= w_rom_pitch;
        r_beats_total <= (w_rom_beats == 4'd0) ? 5'd16 : {1'b0, w_rom_beats};
        r_last        <= bus.last_in;
        r_pre         <= '0;
        r_beat        <= '0;
      end else if (r_state == ST_PLAY) begin
        if (r_pre == c_pre_max) begin
          r_pre  <= '0;
          r_beat <= r_beat + 5'd1;
        end else begin
          r_pre  <= r_pre + c_pre_w'(1);
        end
      end

      if (w_next_state == ST_IDLE) r_pitch <= '0;
    end
  end

  // ------------------------------------------------------------------
  // Tone generation
  // ------------------------------------------------------------------
  tone_div #(
    .HP_W (c_hp_w)
  ) u_tone_div (
    .clk  (clk),
    .rstn (rstn),
    .load (w_latch),
    .en   (r_state == ST_PLAY),
    .hp   (w_hp_tab[w_rom_pitch]),
    .tone (w_tone)
  );

`ifdef NOTE_GAP_EN
  localparam logic [c_pre_w-1:0] c_gap_start = c_pre_w'((3 * c_beat_div) / 4);
  assign w_gap = w_final_beat && (r_pre >= c_gap_start);
`else
  assign w_gap = 1'b0;
`endif

  assign bus.buzz      = w_tone && (r_state == ST_PLAY) && !w_gap;
  assign bus.note_step = (r_state == ST_STEP);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.song_done = r_song_done;
  assign bus.cur_pitch = r_pitch;

endmodule
`default_nettype wire

// File: tb/tb_note_player.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_note_player                                            |
// | Desc     : Directed + random note sequences against a timing model.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_note_player;

  localparam int CLK_HZ   = 100_000;
  localparam int BEAT_HZ  = 100;
  localparam int ROM_LAT  = 1;
  localparam int BEAT_DIV = CLK_HZ / BEAT_HZ;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_err;

  int freq_tab [16] = '{0, 262, 294, 330, 349, 392, 440, 494,
                        523, 587, 659, 698, 784, 880, 988, 1047};

  note_player_if bus ();

  note_player #(
    .CLK_HZ  (CLK_HZ),
    .BEAT_HZ (BEAT_HZ),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input logic [7:0] w);
    return (w[3:0] == 4'd0) ? 16 : int'(w[3:0]);
  endfunction

  function automatic int hp_of(input logic [7:0] w);
    int f;
    f = freq_tab[w[7:4]];
    return (f == 0) ? 0 : CLK_HZ / (2 * f);
  endfunction

  // Called in the STEP cycle; walks FETCH and PLAY, ends in the cycle after PLAY.
  task automatic run_note(input logic [7:0] word, input logic last, input logic lp, input string tag);
    int   d;
    int   hp;
    int   bad;
    int   gap_from;
    logic exp_buzz;
    bus.rom_data = word;
    bus.last_in  = last;
    bus.loop     = lp;
    d        = beats_of(word) * BEAT_DIV;
    hp       = hp_of(word);
    gap_from = d;
`ifdef NOTE_GAP_EN
    gap_from = d - BEAT_DIV + (3 * BEAT_DIV) / 4;
`endif
    bad = 0;
    for (int c = 0; c < ROM_LAT + 1; c++) begin
      @(negedge clk);
      if (bus.note_step !== 1'b0 || bus.busy !== 1'b1 || bus.buzz !== 1'b0) bad++;
    end
    for (int k = 0; k < d; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, "_cur_pitch"}, 32'(bus.cur_pitch), 32'(word[7:4]));
      exp_buzz = (hp == 0) ? 1'b0 : 1'((k / hp) % 2);
      if (k >= gap_from) exp_buzz = 1'b0;
      if (bus.buzz !== exp_buzz || bus.note_step !== 1'b0 ||
          bus.busy !== 1'b1 || bus.song_done !== 1'b0) bad++;
    end
    chk({tag, "_wave_bad_cycles"}, 32'(bad), 32'd0);
    @(negedge clk);
    if (last && !lp) begin
      chk({tag, "_end_done_busy_step"},
          {29'd0, bus.song_done, bus.busy, bus.note_step}, 32'b100);
      chk({tag, "_end_cur_pitch"}, 32'(bus.cur_pitch), 32'd0);
    end else begin
      chk({tag, "_end_step_done"}, {30'd0, bus.note_step, bus.song_done}, 32'b10);
    end
  endtask

  initial begin
    logic [7:0] w;
    int         cnt;
    n_chk        = 0;
    n_err        = 0;
    rstn         = 1'b0;
    bus.play     = 1'b1;
    bus.loop     = 1'b1;
    bus.rom_data = 8'h00;
    bus.last_in  = 1'b0;

    // Reset held with play asserted
    repeat (4) @(negedge clk);
    chk("reset_outputs",
        {24'd0, bus.note_step, bus.buzz, bus.busy, bus.song_done, bus.cur_pitch}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("first_step_after_reset", {31'd0, bus.note_step}, 32'd1);

    // Directed notes: A4 2 beats, rest 3 beats, 16-beat note, gap-sensitive note
    run_note(8'h62, 1'b0, 1'b1, "a4_2beats");
    run_note(8'h03, 1'b0, 1'b1, "rest_3beats");
    run_note(8'h10, 1'b0, 1'b1, "c4_16beats");
    run_note(8'h61, 1'b0, 1'b1, "a4_1beat");

    // Random notes, last_in random but looping
    for (int i = 0; i < 6; i++) begin
      w = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 3))};
      run_note(w, 1'($urandom % 2), 1'b1, $sformatf("rand%0d", i));
    end

    // Last note without loop: song ends, stays parked while play remains high
    run_note(8'hF1, 1'b1, 1'b0, "last_noloop");
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.note_step !== 1'b0 || bus.song_done !== 1'b0 || bus.busy !== 1'b0) cnt++;
    end
    chk("parked_after_song", 32'(cnt), 32'd0);
    bus.play = 1'b0;
    @(negedge clk);
    bus.play = 1'b1;
    @(negedge clk);
    chk("restart_step", {31'd0, bus.note_step}, 32'd1);

    // Last note with loop: keeps stepping
    run_note(8'h31, 1'b1, 1'b1, "last_loop");

    // Drop play mid-note
    bus.rom_data = 8'h62;
    bus.last_in  = 1'b0;
    repeat (ROM_LAT + 1 + 400) @(negedge clk);
    chk("mid_play_buzz_high", {31'd0, bus.buzz}, 32'd1);
    bus.play = 1'b0;
    @(negedge clk);
    chk("drop_buzz_busy_pitch",
        {26'd0, bus.buzz, bus.busy, bus.cur_pitch}, 32'd0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.note_step !== 1'b0 || bus.song_done !== 1'b0 || bus.busy !== 1'b0) cnt++;
    end
    chk("idle_while_stopped", 32'(cnt), 32'd0);
    bus.play = 1'b1;
    @(negedge clk);
    chk("replay_step", {31'd0, bus.note_step}, 32'd1);
    run_note(8'h22, 1'b1, 1'b0, "after_replay");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
